// File: rtl/button_debounce_pkg.sv
// Shared board timing constants (10 kHz LFOSC domain) and debounce FSM types.
package button_debounce_pkg;

    localparam int unsigned LFOSC_HZ     = 10000;
    localparam int unsigned TICKS_PER_MS = LFOSC_HZ / 1000;

    localparam int unsigned DEFAULT_DEBOUNCE_TICKS   = 20 * TICKS_PER_MS;
    localparam int unsigned DEFAULT_LONG_PRESS_TICKS = 1000 * TICKS_PER_MS;

    typedef enum logic [2:0] {
        StIdle,
        StPressWait,
        StHeld,
        StLongHeld,
        StReleaseWait
    } btn_state_e;

    // Counter width for a terminal count of n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with asynchronous reset to a configurable level.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_debounce.sv
// Pushbutton debouncer: debounced level, press/release/long-press strobes and a
// wrapping press counter.
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS   = DEFAULT_DEBOUNCE_TICKS,
    parameter int unsigned LONG_PRESS_TICKS = DEFAULT_LONG_PRESS_TICKS,
    parameter bit          ACTIVE_LOW       = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       pressed,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [7:0] press_count
);

    localparam int unsigned DBW = cnt_width(DEBOUNCE_TICKS);
    localparam int unsigned HW  = cnt_width(LONG_PRESS_TICKS);

    localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_TICKS - 1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_PRESS_TICKS - 1);

    logic btn_sync;
    logic btn_s_q, btn_s_d;

    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic           pressed_q, pressed_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic           long_done_q, long_done_d;
    btn_state_e     state_q, state_d;

    logic       press_pulse_q, release_pulse_q, long_pulse_q;
    logic [7:0] press_count_q, press_count_d;

    logic differ;
    logic accept;
    logic press_acc;
    logic rel_acc;
    logic hold_active;
    logic long_fire;

    // Reset the synchronizer to the released raw level so reset never looks like a press.
    sync_2ff #(
        .RESET_VAL(ACTIVE_LOW)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (btn_in),
        .q_o (btn_sync)
    );

    assign btn_s_d = btn_sync ^ ACTIVE_LOW;

    always_comb begin
        differ    = (btn_s_q != pressed_q);
        accept    = differ && (db_cnt_q == DB_LAST);
        press_acc = accept && !pressed_q;
        rel_acc   = accept && pressed_q;
        pressed_d = pressed_q ^ accept;
        db_cnt_d  = (!differ || accept) ? '0 : db_cnt_q + 1'b1;
    end

    always_comb begin
        hold_active = (state_q == StHeld) || (state_q == StLongHeld) ||
                      (state_q == StReleaseWait);
        long_fire   = !rel_acc && (hold_q == HOLD_LAST) &&
                      ((state_q == StHeld) || ((state_q == StReleaseWait) && !long_done_q));

        hold_d = hold_q;
        if (press_acc) begin
            hold_d = '0;
        end else if (hold_active && (hold_q != HOLD_LAST)) begin
            hold_d = hold_q + 1'b1;
        end

        long_done_d = long_done_q;
        if (press_acc) begin
            long_done_d = 1'b0;
        end else if (long_fire) begin
            long_done_d = 1'b1;
        end

        press_count_d = press_count_q + {7'd0, press_acc};
    end

    // Accept can coincide with the first cycle of a level change when DEBOUNCE_TICKS is 1,
    // so each state checks accept before its wait-state transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (btn_s_q) begin
                    state_d = accept ? StHeld : StPressWait;
                end
            end
            StPressWait: begin
                if (accept) begin
                    state_d = StHeld;
                end else if (!btn_s_q) begin
                    state_d = StIdle;
                end
            end
            StHeld: begin
                if (!btn_s_q) begin
                    state_d = accept ? StIdle : StReleaseWait;
                end else if (long_fire) begin
                    state_d = StLongHeld;
                end
            end
            StLongHeld: begin
                if (!btn_s_q) begin
                    state_d = accept ? StIdle : StReleaseWait;
                end
            end
            StReleaseWait: begin
                if (accept) begin
                    state_d = StIdle;
                end else if (btn_s_q) begin
                    state_d = (long_done_q || long_fire) ? StLongHeld : StHeld;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s_q         <= 1'b0;
            db_cnt_q        <= '0;
            pressed_q       <= 1'b0;
            hold_q          <= '0;
            long_done_q     <= 1'b0;
            state_q         <= StIdle;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            long_pulse_q    <= 1'b0;
            press_count_q   <= 8'd0;
        end else begin
            btn_s_q         <= btn_s_d;
            db_cnt_q        <= db_cnt_d;
            pressed_q       <= pressed_d;
            hold_q          <= hold_d;
            long_done_q     <= long_done_d;
            state_q         <= state_d;
            press_pulse_q   <= press_acc;
            release_pulse_q <= rel_acc;
            long_pulse_q    <= long_fire;
            press_count_q   <= press_count_d;
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign long_pulse    = long_pulse_q;
    assign press_count   = press_count_q;

endmodule
